full_adder_1bit: RTL and testbench
==================================

// Module: full_adder_1bit
// PURPOSE
//  Single-bit full adder with a registered output stage. Leaf arithmetic cell for
//  the datapath's ripple/accumulator chains. Adds A + B + Cin; drives Sum and Cout.
// PARAMETERS
//  REG_OUT  default 1  1: Sum/Cout registered (latency 1 clk); 0: combinational (latency 0)
// PORTS
//  clk   in   1  system clock; all state on rising edge
//  rst   in   1  synchronous, active-high reset
//  A     in   1  addend
//  B     in   1  addend
//  Cin   in   1  carry in
//  Sum   out  1  A ^ B ^ Cin
//  Cout  out  1  majority(A, B, Cin) = (A&B) | (A&Cin) | (B&Cin)
//  Seen  out  8  coverage bitmap; present only with FA_COVERAGE_EN (see CONFIGURATION)
//  Interface fixed: one clock (clk); reset rst is synchronous and active-high.
// BEHAVIOUR
//  - Arithmetic: {Cout,Sum} = A + B + Cin as a 2-bit unsigned result; never X for 0/1 inputs.
//  - Truth table, index {A,B,Cin} = 0..7: Sum = 0,1,1,0,1,0,0,1; Cout = 0,0,0,1,0,1,1,1.
//  - REG_OUT=1: at each rising clk, if rst then Sum<=0, Cout<=0; else Sum/Cout <= f(A,B,Cin)
//    sampled at that edge. Outputs change only on clk edges; input glitches between edges invisible.
//  - REG_OUT=0: Sum/Cout follow inputs combinationally; rst has no effect on them.
//  - Reset value of every registered output: 0 (Sum=0, Cout=0, Seen=8'h00).
//  - rst asserted mid-stream: outputs 0 at the first edge with rst=1, held while rst=1;
//    first valid result is from inputs sampled at first edge with rst=0.
//  - No handshake, no backpressure; a new input triple is accepted every cycle.
//  - Input change on the same edge as rst deassertion: result reflects the inputs sampled at that edge.
// CONFIGURATION
//  FA_COVERAGE_EN defined: port Seen[7:0] exists. At each non-reset rising edge,
//    Seen[{A,B,Cin}] <= 1 (sticky). rst clears Seen to 8'h00 synchronously.
//    Seen is always registered, independent of REG_OUT. Seen==8'hFF means full truth table exercised.
//  FA_COVERAGE_EN undefined: Seen port and its logic absent. Sum/Cout behaviour identical.
// STRUCTURE
//  - Package fa_pkg: localparam SUM_TT = 8'b1001_0110, COUT_TT = 8'b1110_1000
//    (bit i = result for {A,B,Cin}=i); typedef fa_idx_t = logic [2:0].
//  - Sub-module fa_core: purely combinational Sum/Cout from A,B,Cin (gate form).
//  - Top: fa_core instance + REG_OUT generate register stage + optional coverage register.
// TESTING
//  - rst=1 for 2 clks with A=B=Cin=1 -> Sum=0, Cout=0 (REG_OUT=1); Seen=8'h00.
//  - Sweep {A,B,Cin}=0..7, one per clk -> one clk later {Cout,Sum} = 00,01,01,10,01,10,10,11.
//  - Check every result against SUM_TT/COUT_TT in both REG_OUT=1 and REG_OUT=0 builds
//    (REG_OUT=0: compare after 1 ns settle).
//  - Drive {A,B,Cin}=3'b111, then assert rst for 1 clk -> outputs 0 that cycle.
//    Release rst with 3'b011 -> next cycle Sum=0, Cout=1.
//  - FA_COVERAGE_EN: drive only 3'b000 and 3'b101 -> Seen=8'h21.
//    After full sweep -> Seen=8'hFF. rst -> 8'h00.
//  - Random 1000 cycles of A/B/Cin -> {Cout,Sum} == A+B+Cin (delayed per REG_OUT), zero mismatches.

Source files
------------

// File: rtl/fa_pkg.sv
// Shared definitions for the 1-bit full adder cell: reference truth tables and
// the {A,B,Cin} index type used by the optional coverage bitmap.
package fa_pkg;

    // Bit i holds the result for {A,B,Cin} == i.
    localparam logic [7:0] SUM_TT  = 8'b1001_0110;
    localparam logic [7:0] COUT_TT = 8'b1110_1000;

    typedef logic [2:0] fa_idx_t;

    function automatic fa_idx_t fa_idx(input logic a, input logic b, input logic c);
        return {a, b, c};
    endfunction

endpackage

// File: rtl/fa_core.sv
// Combinational full-adder core in gate form.
// The carry reuses the A^B term so that Sum and Cout share one XOR.
module fa_core (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_ab_x;

    assign w_ab_x = i_a ^ i_b;
    assign o_sum  = w_ab_x ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & w_ab_x);

endmodule

// File: rtl/full_adder_1bit.sv
// 1-bit full adder with an optional registered output stage (REG_OUT).
// Define FA_COVERAGE_EN to add the sticky Seen[7:0] input-pattern bitmap.
module full_adder_1bit
    import fa_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       A,
    input  logic       B,
    input  logic       Cin,
    output logic       Sum,
`ifdef FA_COVERAGE_EN
    output logic [7:0] Seen,
`endif
    output logic       Cout
);

    logic w_sum;
    logic w_cout;

    fa_core u_core (
        .i_a    (A),
        .i_b    (B),
        .i_cin  (Cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    generate
        if (REG_OUT) begin : g_reg
            logic r_sum;
            logic r_cout;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sum  <= 1'b0;
                    r_cout <= 1'b0;
                end else begin
                    r_sum  <= w_sum;
                    r_cout <= w_cout;
                end
            end

            assign Sum  = r_sum;
            assign Cout = r_cout;
        end else begin : g_comb
            // Clock and reset only matter here when the coverage register exists.
            logic w_unused;
            assign w_unused = clk ^ rst;

            assign Sum  = w_sum;
            assign Cout = w_cout;
        end
    endgenerate

`ifdef FA_COVERAGE_EN
    fa_idx_t    w_idx;
    logic [7:0] r_seen;

    assign w_idx = fa_idx(A, B, Cin);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seen <= 8'h00;
        end else begin
            r_seen <= r_seen | (8'd1 << w_idx);
        end
    end

    assign Seen = r_seen;
`endif

endmodule

// File: tb/tb_full_adder_1bit.sv
// Self-checking bench for full_adder_1bit: registered and combinational builds
// side by side, checked against A+B+Cin arithmetic and a bitmap model of Seen.
module tb_full_adder_1bit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a   = 1'b1;
    logic b   = 1'b1;
    logic cin = 1'b1;

    logic sum_r, cout_r, sum_c, cout_c;
`ifdef FA_COVERAGE_EN
    logic [7:0] seen_r, seen_c;
`endif

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] seen_m = 8'h00;
    logic [1:0] sweep_tab [8];

    always #5 clk = ~clk;

    full_adder_1bit #(.REG_OUT(1'b1)) dut_reg (
        .clk  (clk),
        .rst  (rst),
        .A    (a),
        .B    (b),
        .Cin  (cin),
        .Sum  (sum_r),
`ifdef FA_COVERAGE_EN
        .Seen (seen_r),
`endif
        .Cout (cout_r)
    );

    full_adder_1bit #(.REG_OUT(1'b0)) dut_comb (
        .clk  (clk),
        .rst  (rst),
        .A    (a),
        .B    (b),
        .Cin  (cin),
        .Sum  (sum_c),
`ifdef FA_COVERAGE_EN
        .Seen (seen_c),
`endif
        .Cout (cout_c)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive on the falling edge, check the combinational build after
    // a settle, then check the registered build just after the rising edge.
    task automatic step(input logic [2:0] v, input logic r, input string tag);
        logic [1:0] exp;
        @(negedge clk);
        {a, b, cin} = v;
        rst = r;
        #1;
        exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
        chk({tag, "_comb"}, {6'd0, cout_c, sum_c}, {6'd0, exp});
        @(posedge clk);
        if (r) begin
            exp    = 2'd0;
            seen_m = 8'h00;
        end else begin
            seen_m[v] = 1'b1;
        end
        #1;
        chk({tag, "_reg"}, {6'd0, cout_r, sum_r}, {6'd0, exp});
`ifdef FA_COVERAGE_EN
        chk({tag, "_seen_r"}, seen_r, seen_m);
        chk({tag, "_seen_c"}, seen_c, seen_m);
`endif
    endtask

    initial begin
        sweep_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        step(3'b111, 1'b1, "rst0");
        step(3'b111, 1'b1, "rst1");
        chk("rst_zero", {6'd0, cout_r, sum_r}, 8'h00);

        step(3'b000, 1'b0, "cov0");
        step(3'b101, 1'b0, "cov5");
`ifdef FA_COVERAGE_EN
        chk("seen_21", seen_r, 8'h21);
`endif

        for (int i = 0; i < 8; i++) begin
            step(3'(i), 1'b0, "sweep");
            chk("sweep_tab", {6'd0, cout_r, sum_r}, {6'd0, sweep_tab[i]});
        end
`ifdef FA_COVERAGE_EN
        chk("seen_ff", seen_r, 8'hFF);
`endif

        step(3'b111, 1'b0, "mid_pre");
        step(3'b111, 1'b1, "mid_rst");
        chk("mid_rst_zero", {6'd0, cout_r, sum_r}, 8'h00);
`ifdef FA_COVERAGE_EN
        chk("seen_clr", seen_r, 8'h00);
`endif
        step(3'b011, 1'b0, "mid_rel");
        chk("mid_rel_011", {6'd0, cout_r, sum_r}, 8'h02);

        for (int i = 0; i < 1000; i++) begin
            step(3'($urandom_range(0, 7)), ($urandom_range(0, 63) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
